spi_master_driver: RTL and testbench
====================================

Name: spi_master_driver

Overview:
SPI master controller, CPOL=0 CPHA=0, LSB-first, 8-bit frames. Sits directly upstream of spi_slave_driver and drives its spi_sclk/spi_mosi/spi_cs while capturing spi_miso. The system side loads one byte and pulses start. The block then runs one full-duplex transfer and returns the byte received from the slave. All SPI outputs are generated from clk_i.

Parameters:
CLK_DIV, 4, SCLK half-period in clk_i cycles; legal range 2..255; SCLK period = 2*CLK_DIV cycles.

Ports:
clk_i  input  1  system clock
rst_i  input  1  synchronous active-high reset
data_in_bi  input  8  byte to transmit; sampled when a start is accepted
start_i  input  1  transfer request; accepted only when busy_bo=0
data_out_bo  output  8  byte received in last completed transfer
busy_bo  output  1  high from accepted start until end of CS gap
done_o  output  1  one-cycle pulse at transfer completion
spi_sclk_o  output  1  serial clock, idles low
spi_mosi_o  output  1  master-out data
spi_miso_i  input  1  master-in data
spi_cs_o  output  1  chip select, active low, idles high

Behaviour:
- Reset applies to all outputs and state (also mid-transfer):
  - spi_cs_o=1, spi_sclk_o=0, spi_mosi_o=0, busy_bo=0, done_o=0, data_out_bo=0.
  - tx/rx shift registers, bit counter and divider counter are cleared.
  - State goes to IDLE.
- Reset is synchronous: it takes effect on the clk_i edge where rst_i=1.
- All outputs are registered.
- Divider: a counter runs 0..CLK_DIV-1 in every non-IDLE state. A "tick" is counter==CLK_DIV-1; the counter reloads to 0 on each tick and on every state change.
- States:
  - IDLE: outputs idle. If start_i=1, latch tx<=data_in_bi, clear rx and bit_cnt. Next cycle: spi_cs_o=0, spi_mosi_o=data_in_bi[0], busy_bo=1 -> SETUP.
  - SETUP: CS setup, SCLK low. On tick: spi_sclk_o<=1, rx<={spi_miso_i, rx[7:1]} -> HIGH.
  - HIGH: on tick, spi_sclk_o<=0 and bit_cnt<=bit_cnt+1.
    - If bit_cnt==7 -> HOLD.
    - Else tx<={1'b0, tx[7:1]}, spi_mosi_o<=tx[1] -> LOW.
  - LOW: on tick: spi_sclk_o<=1, sample MISO into rx as above -> HIGH.
  - HOLD: CS hold, SCLK low. On tick: spi_cs_o<=1, data_out_bo<=rx, done_o<=1 for one cycle, spi_mosi_o<=0 -> GAP.
  - GAP: CS high, busy_bo still 1. On tick: busy_bo<=0 -> IDLE.
- Timing:
  - CS low for exactly 18*CLK_DIV cycles.
  - Exactly 8 SCLK rising edges per transfer.
  - Start acceptance to busy_bo falling: 19*CLK_DIV+1 cycles.
- MOSI changes only on SCLK falling edges or at CS assertion. MISO is sampled on the clk_i edge that raises SCLK; the slave holds MISO stable through the low half-period.
- Bit order: tx bit i is driven during SCLK period i. The MISO bit captured at rising edge i lands in rx[i] after 8 shifts.
- start_i while busy_bo=1 is ignored, with no queueing. data_in_bi changes during a transfer have no effect.
- Back-to-back: a start held high is accepted the cycle busy_bo falls. Minimum CS-high gap is CLK_DIV+1 cycles.
- data_out_bo holds its value until the next done_o.

Decomposition:
- Shared package spi_pkg: state encoding localparams (IDLE, SETUP, HIGH, LOW, HOLD, GAP), SPI_FRAME_BITS=8, default CLK_DIV.
- One natural sub-module: spi_half_tick, the CLK_DIV counter with sync clear, emitting tick. The FSM and shifters stay in the top.

Test Plan:
- Loopback with spi_slave_driver, CLK_DIV=4: master data_in 0xA5, slave data_in 0x3C, pulse start -> done_o after 72+1 cycles; master data_out_bo=0x3C, slave data_out_bo=0xA5.
- Edge/timing check, CLK_DIV=4: count spi_sclk_o rising edges while spi_cs_o=0 -> exactly 8.
  - Check CS low duration = 72 cycles.
  - Check MOSI stable across every SCLK rising edge.
- Bit order: MISO model returns 0x01, then 0x80 -> data_out_bo=0x01, then 0x80. MOSI with tx=0x01 is high only in the first SCLK period.
- start_i pulsed mid-transfer with data_in 0xFF -> ignored; the transfer in flight completes unchanged and no second CS assertion occurs.
- rst_i asserted at SCLK edge 4 -> next cycle cs=1, sclk=0, mosi=0, busy=0, data_out_bo=0. A subsequent start 0x5A/0xC3 completes correctly.
- start_i held high, CLK_DIV=2 -> consecutive transfers with CS high for exactly 3 cycles between them; each done_o is one cycle wide.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared constants and FSM state type for the SPI master.
// Frame width and the default SCLK half-period live here.
package spi_pkg;
    localparam int SPI_FRAME_BITS  = 8;
    localparam int CLK_DIV_DEFAULT = 4;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        HIGH,
        LOW,
        HOLD,
        GAP
    } spi_state_t;
endpackage

// File: rtl/spi_half_tick.sv
// SCLK half-period divider: counts 0..DIV-1 and flags the last count.
// Latency: tick is decoded from the counter in the same cycle.
// Backpressure: none; clr holds the counter at zero.
module spi_half_tick #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic clr,
    output logic tick
);
    logic [7:0] cnt;

    assign tick = (cnt == 8'(DIV - 1));

    always_ff @(posedge clk) begin
        if (clr || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 8'd1;
        end
    end
endmodule

// File: rtl/spi_master_driver.sv
// SPI master, CPOL=0 CPHA=0, LSB first, one 8-bit full-duplex frame per start.
// Latency: start to done is 18*CLK_DIV+1 cycles; busy drops CLK_DIV cycles later.
// Backpressure: start_i is ignored while busy_bo is high; nothing is queued.
module spi_master_driver
    import spi_pkg::*;
#(
    parameter int CLK_DIV = CLK_DIV_DEFAULT
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [7:0] data_in_bi,
    input  logic       start_i,
    output logic [7:0] data_out_bo,
    output logic       busy_bo,
    output logic       done_o,
    output logic       spi_sclk_o,
    output logic       spi_mosi_o,
    input  logic       spi_miso_i,
    output logic       spi_cs_o
);
    localparam logic [3:0] LAST_BIT  = 4'(SPI_FRAME_BITS - 1);
    localparam logic [3:0] FRAME_CNT = 4'(SPI_FRAME_BITS);

    spi_state_t state;
    logic [6:0] tx;
    logic [7:0] rx;
    logic [3:0] bit_cnt;
    logic       tick;

    spi_half_tick #(.DIV(CLK_DIV)) u_half_tick (
        .clk  (clk_i),
        .clr  (rst_i || state == IDLE),
        .tick (tick)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= IDLE;
            tx          <= '0;
            rx          <= '0;
            bit_cnt     <= '0;
            data_out_bo <= '0;
            busy_bo     <= 1'b0;
            done_o      <= 1'b0;
            spi_sclk_o  <= 1'b0;
            spi_mosi_o  <= 1'b0;
            spi_cs_o    <= 1'b1;
        end else begin
            done_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_i) begin
                        // Bit 0 goes straight to MOSI; tx keeps the remaining bits.
                        tx         <= data_in_bi[7:1];
                        rx         <= '0;
                        bit_cnt    <= '0;
                        spi_cs_o   <= 1'b0;
                        spi_mosi_o <= data_in_bi[0];
                        busy_bo    <= 1'b1;
                        state      <= SETUP;
                    end
                end
                SETUP, LOW: begin
                    if (tick) begin
                        spi_sclk_o <= 1'b1;
                        rx         <= {spi_miso_i, rx[7:1]};
                        state      <= HIGH;
                    end
                end
                HIGH: begin
                    if (tick) begin
                        spi_sclk_o <= 1'b0;
                        bit_cnt    <= bit_cnt + 4'd1;
                        if (bit_cnt == LAST_BIT) begin
                            state <= HOLD;
                        end else begin
                            spi_mosi_o <= tx[0];
                            tx         <= {1'b0, tx[6:1]};
                            state      <= LOW;
                        end
                    end
                end
                HOLD: begin
                    // CS hold spans two half-periods so CS stays low 18*CLK_DIV cycles.
                    if (tick) begin
                        if (bit_cnt == FRAME_CNT) begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end else begin
                            spi_cs_o    <= 1'b1;
                            spi_mosi_o  <= 1'b0;
                            data_out_bo <= rx;
                            done_o      <= 1'b1;
                            state       <= GAP;
                        end
                    end
                end
                GAP: begin
                    if (tick) begin
                        busy_bo <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_master_driver.sv
// Bench for spi_master_driver: two instances (CLK_DIV 4 and 2), a behavioural
// SPI slave, and a cycle-position model of the expected pin waveforms.
module tb_spi_master_driver;
    localparam int NI = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst   [NI];
    logic       start [NI];
    logic [7:0] din   [NI];
    logic [7:0] sbyte [NI];
    logic       miso  [NI];
    logic [7:0] dout  [NI];
    logic       busy  [NI];
    logic       done  [NI];
    logic       sclk  [NI];
    logic       mosi  [NI];
    logic       cs    [NI];
    logic [7:0] slat  [NI];
    logic [7:0] srx   [NI];

    int n_chk  = 0;
    int n_fail = 0;
    bit fin0 = 1'b0;
    bit fin1 = 1'b0;

    int x_cs_low, x_rises, x_mosi_hi, x_done_at, x_unstable, x_cs_falls, x_end;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_idle(input int i, input string tag);
        check({tag, "_cs"}, 32'(cs[i]), 32'd1);
        check({tag, "_sclk"}, 32'(sclk[i]), 32'd0);
        check({tag, "_mosi"}, 32'(mosi[i]), 32'd0);
        check({tag, "_busy"}, 32'(busy[i]), 32'd0);
        check({tag, "_done"}, 32'(done[i]), 32'd0);
        check({tag, "_dout"}, 32'(dout[i]), 32'd0);
    endtask

    // Expected {cs, sclk, mosi, busy, done} at cycle t after start acceptance (t=0: idle).
    function automatic logic [4:0] model_pins(input int t, input int d, input logic [7:0] tx);
        int  h;
        int  bi;
        logic cs_low;
        if (t == 0) return 5'b10000;
        h = (t - 1) / d;
        bi = (h / 2 > 7) ? 7 : h / 2;
        cs_low = (t <= 18 * d);
        return {!cs_low, (h % 2 == 1) && (t <= 16 * d), cs_low && tx[3'(bi)], 1'b1, t == 18 * d + 1};
    endfunction

    for (genvar g = 0; g < NI; g++) begin : inst
        localparam int D = (g == 0) ? 4 : 2;

        spi_master_driver #(.CLK_DIV(D)) dut (
            .clk_i       (clk),
            .rst_i       (rst[g]),
            .data_in_bi  (din[g]),
            .start_i     (start[g]),
            .data_out_bo (dout[g]),
            .busy_bo     (busy[g]),
            .done_o      (done[g]),
            .spi_sclk_o  (sclk[g]),
            .spi_mosi_o  (mosi[g]),
            .spi_miso_i  (miso[g]),
            .spi_cs_o    (cs[g])
        );

        int         t = 0;
        logic [7:0] mtx = 8'h00;
        logic [7:0] mdout = 8'h00;
        bit         armed = 1'b0;
        int         fidx = 0;
        logic       pcs = 1'b1;
        logic       psclk = 1'b0;

        always @(posedge clk) begin
            if (rst[g]) begin
                t = 0;
                mdout = 8'h00;
                armed = 1'b1;
            end else if (t == 0) begin
                if (start[g]) begin
                    t = 1;
                    mtx = din[g];
                end
            end else begin
                t++;
                if (t == 18 * D + 1) mdout = slat[g];
                if (t > 19 * D) t = 0;
            end
        end

        // Slave: bit i valid from CS fall / i-th SCLK fall, garbage while SCLK is high.
        always @(negedge clk) begin
            if (cs[g] !== 1'b0) begin
                fidx = 0;
                miso[g] = 1'($urandom);
            end else begin
                if (pcs) begin
                    slat[g] = sbyte[g];
                    srx[g] = 8'h00;
                    fidx = 0;
                end else if (psclk && !sclk[g]) begin
                    fidx++;
                end else if (!psclk && sclk[g]) begin
                    srx[g] = {mosi[g], srx[g][7:1]};
                end
                if (sclk[g] || fidx > 7) miso[g] = 1'($urandom);
                else miso[g] = slat[g][fidx[2:0]];
            end
            pcs = cs[g];
            psclk = sclk[g];
        end

        always @(negedge clk) begin : cmp
            logic [4:0] e;
            e = model_pins(t, D, mtx);
            if (armed) begin
                check($sformatf("i%0d_cs", g), 32'(cs[g]), 32'(e[4]));
                check($sformatf("i%0d_sclk", g), 32'(sclk[g]), 32'(e[3]));
                check($sformatf("i%0d_mosi", g), 32'(mosi[g]), 32'(e[2]));
                check($sformatf("i%0d_busy", g), 32'(busy[g]), 32'(e[1]));
                check($sformatf("i%0d_done", g), 32'(done[g]), 32'(e[0]));
                check($sformatf("i%0d_dout", g), 32'(dout[g]), 32'(mdout));
            end
        end
    end

    // One transfer on instance 0, measuring pin statistics; optional stray start at cycle inject.
    task automatic xfer0(input logic [7:0] m, input logic [7:0] s, input int inject);
        logic ps = 1'b0;
        logic pm = 1'b0;
        logic pc = 1'b1;
        int   k;
        x_cs_low = 0; x_rises = 0; x_mosi_hi = 0; x_done_at = -1; x_unstable = 0; x_cs_falls = 0;
        @(negedge clk);
        din[0] = m;
        sbyte[0] = s;
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        k = 1;
        while (k < 400) begin
            if (k == inject) begin start[0] = 1'b1; din[0] = 8'hFF; end
            if (k == inject + 1) start[0] = 1'b0;
            if (!cs[0]) begin
                x_cs_low++;
                if (pc) x_cs_falls++;
                if (mosi[0]) x_mosi_hi++;
                if (sclk[0] && !ps) begin
                    x_rises++;
                    if (mosi[0] !== pm) x_unstable++;
                end
            end
            if (done[0] && x_done_at < 0) x_done_at = k;
            if (!busy[0]) break;
            ps = sclk[0]; pm = mosi[0]; pc = cs[0];
            @(negedge clk);
            k++;
        end
        start[0] = 1'b0;
        x_end = k;
        check("xfer_bounded", 32'(k < 400), 32'd1);
    endtask

    initial begin : stim0
        int r;
        int nd;
        logic ps;
        rst[0] = 1'b1; start[0] = 1'b0; din[0] = 8'h00; sbyte[0] = 8'h00;
        repeat (3) @(negedge clk);
        check_idle(0, "reset0");
        rst[0] = 1'b0;

        xfer0(8'hA5, 8'h3C, 0);
        check("loop_master_rx", 32'(dout[0]), 32'h3C);
        check("loop_slave_rx", 32'(srx[0]), 32'hA5);
        check("cs_low_cycles", 32'(x_cs_low), 32'd72);
        check("sclk_rises", 32'(x_rises), 32'd8);
        check("done_cycle", 32'(x_done_at), 32'd73);
        check("busy_fall_cycle", 32'(x_end), 32'd77);
        check("mosi_stable", 32'(x_unstable), 32'd0);

        xfer0(8'h01, 8'h01, 0);
        check("order_rx_01", 32'(dout[0]), 32'h01);
        check("order_mosi_01", 32'(x_mosi_hi), 32'd8);
        xfer0(8'h80, 8'h80, 0);
        check("order_rx_80", 32'(dout[0]), 32'h80);
        check("order_mosi_80", 32'(x_mosi_hi), 32'd16);

        xfer0(8'h3C, 8'h96, 30);
        check("ignore_rx", 32'(dout[0]), 32'h96);
        check("ignore_tx", 32'(srx[0]), 32'h3C);
        check("ignore_cs_falls", 32'(x_cs_falls), 32'd1);
        check("ignore_len", 32'(x_end), 32'd77);

        @(negedge clk);
        din[0] = 8'h11; sbyte[0] = 8'h22; start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        r = 0; ps = 1'b0;
        for (int k = 0; k < 200 && r < 4; k++) begin
            @(negedge clk);
            if (sclk[0] && !ps) r++;
            ps = sclk[0];
        end
        check("rst_edge_reached", 32'(r), 32'd4);
        rst[0] = 1'b1;
        @(negedge clk);
        check_idle(0, "midrst");
        rst[0] = 1'b0;
        xfer0(8'h5A, 8'hC3, 0);
        check("post_rst_rx", 32'(dout[0]), 32'hC3);
        check("post_rst_tx", 32'(srx[0]), 32'h5A);

        nd = 0;
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            if (done[0]) nd++;
            start[0] = ($urandom_range(0, 5) == 0);
            din[0] = 8'($urandom);
            sbyte[0] = 8'($urandom);
            rst[0] = ($urandom_range(0, 399) == 0);
        end
        rst[0] = 1'b0; start[0] = 1'b0;
        check("random_transfers", 32'(nd >= 20), 32'd1);
        repeat (100) @(negedge clk);
        fin0 = 1'b1;
    end

    initial begin : stim1
        int   hi_run;
        int   dw;
        int   gaps;
        bit   seen_low;
        rst[1] = 1'b1; start[1] = 1'b0; din[1] = 8'h00; sbyte[1] = 8'h00;
        repeat (3) @(negedge clk);
        check_idle(1, "reset1");
        rst[1] = 1'b0;
        hi_run = 0; dw = 0; gaps = 0; seen_low = 1'b0;
        start[1] = 1'b1;
        for (int k = 0; k < 250; k++) begin
            @(negedge clk);
            din[1] = 8'($urandom);
            sbyte[1] = 8'($urandom);
            if (cs[1] == 1'b0) begin
                if (seen_low && hi_run > 0) begin
                    check("b2b_cs_gap", 32'(hi_run), 32'd3);
                    gaps++;
                end
                seen_low = 1'b1;
                hi_run = 0;
            end else begin
                hi_run++;
            end
            if (done[1]) dw++;
            else if (dw > 0) begin
                check("b2b_done_width", 32'(dw), 32'd1);
                dw = 0;
            end
        end
        start[1] = 1'b0;
        check("b2b_gap_count", 32'(gaps >= 4), 32'd1);
        for (int k = 0; k < 100 && busy[1]; k++) @(negedge clk);
        check("b2b_settles", 32'(busy[1]), 32'd0);
        fin1 = 1'b1;
    end

    initial begin : summary
        wait (fin0 && fin1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin : watchdog
        #1000000;
        n_fail++;
        $display("FAIL watchdog: bench did not complete within time limit");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $fatal(1);
    end
endmodule
